// File: rtl/resize_scan_controller_if.sv
// Bundles the two buses of the raster-scan sequencer:
//   - source memory read port: rd_en/rd_addr out, rd_data back one cycle later
//   - pixel stream to the output writer: horizontal_sync strobe, r/g/b, out_row/out_col
// master = sequencer side, slave = memory/writer side.
interface resize_scan_controller_if #(
  parameter int ADDR_W = 20
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [23:0]       rd_data;
  logic              horizontal_sync;
  logic [7:0]        r;
  logic [7:0]        g;
  logic [7:0]        b;
  logic [15:0]       out_col;
  logic [15:0]       out_row;

  modport master (
    output rd_en, rd_addr,
    input  rd_data,
    output horizontal_sync, r, g, b, out_col, out_row
  );

  modport slave (
    input  rd_en, rd_addr,
    output rd_data,
    input  horizontal_sync, r, g, b, out_col, out_row
  );
endinterface

// File: rtl/resize_scan_controller.sv
// Raster-scan sequencer: walks the source pixel RAM row-major, one read per
// cycle, with HBLANK idle cycles between rows and a frame_done pulse at the end.
// Latency: rd_en in cycle t, rd_data in t+1, registered pixel on horizontal_sync in t+2.
// Backpressure: stall blocks new reads only; up to 2 in-flight beats still emerge.
// Ports: clock/reset (async, active-low); start (sampled in IDLE); stall;
//   busy (frame in progress, through the frame_done cycle); frame_done (1-cycle pulse);
//   bus: memory read port and pixel output stream (see resize_scan_controller_if).
module resize_scan_controller #(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512,
  parameter int HBLANK = 160,
  parameter int ADDR_W = 20
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic stall,
  output logic busy,
  output logic frame_done,
  resize_scan_controller_if.master bus
);

  localparam logic [15:0] LAST_COL   = 16'(WIDTH - 1);
  localparam logic [15:0] LAST_ROW   = 16'(HEIGHT - 1);
  localparam logic [15:0] BLANK_LAST = 16'(HBLANK - 1);
  // Two pipeline stages (memory read + output register) must empty before DONE.
  localparam logic [15:0] DRAIN_LAST = 16'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACTIVE,
    S_BLANK,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              issue;
  logic [15:0]       col;
  logic [15:0]       row;
  logic [15:0]       cnt;
  logic [ADDR_W-1:0] addr;

  // Pipeline: stage 1 tracks the read in flight, stage 2 is the output register.
  logic        vld1;
  logic [15:0] row1;
  logic [15:0] col1;
  logic        hs_q;
  logic [23:0] rgb_q;
  logic [15:0] row_q;
  logic [15:0] col_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (!stall) begin
          issue = 1'b1;
          if (col == LAST_COL) begin
            if (row == LAST_ROW)  state_nxt = S_DRAIN;
            else if (HBLANK > 0)  state_nxt = S_BLANK;
          end
        end
      end
      S_BLANK: begin
        if (cnt == BLANK_LAST) state_nxt = S_ACTIVE;
      end
      S_DRAIN: begin
        if (cnt == DRAIN_LAST) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Scan counters. The address is kept incrementally alongside row/col so
  // no row*WIDTH product is ever formed.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
      cnt  <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        col  <= '0;
        row  <= '0;
        addr <= '0;
      end else if (issue) begin
        addr <= addr + ADDR_W'(1);
        if (col == LAST_COL) begin
          col <= '0;
          if (row != LAST_ROW) row <= row + 16'd1;
        end else begin
          col <= col + 16'd1;
        end
      end
      // Dwell counter for BLANK/DRAIN; cleared on every state change.
      if ((state == S_BLANK || state == S_DRAIN) && state_nxt == state)
        cnt <= cnt + 16'd1;
      else
        cnt <= '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld1  <= 1'b0;
      row1  <= '0;
      col1  <= '0;
      hs_q  <= 1'b0;
      rgb_q <= '0;
      row_q <= '0;
      col_q <= '0;
    end else begin
      vld1 <= issue;
      if (issue) begin
        row1 <= row;
        col1 <= col;
      end
      hs_q <= vld1;
      // Pixel and coordinates hold their last value between beats.
      if (vld1) begin
        rgb_q <= bus.rd_data;
        row_q <= row1;
        col_q <= col1;
      end
    end
  end

  assign bus.rd_en           = issue;
  assign bus.rd_addr         = addr;
  assign bus.horizontal_sync = hs_q;
  assign bus.r               = rgb_q[23:16];
  assign bus.g               = rgb_q[15:8];
  assign bus.b               = rgb_q[7:0];
  assign bus.out_row         = row_q;
  assign bus.out_col         = col_q;
  assign busy                = (state != S_IDLE);
  assign frame_done          = (state == S_DONE);

endmodule

// File: tb/tb_resize_scan_controller.sv
// Bench for resize_scan_controller: two instances (4x3 with HBLANK=2, 4x2 with
// HBLANK=0) share clock, reset, start and stall; each is compared every cycle
// against a transaction-level model of the scan.
module tb_resize_scan_controller;
  localparam int AW = 20;

  logic clock = 1'b0;
  logic reset;
  logic start;
  logic stall;
  logic busy_a, done_a, busy_b, done_b;

  always #5 clock = ~clock;

  resize_scan_controller_if #(.ADDR_W(AW)) ifa ();
  resize_scan_controller_if #(.ADDR_W(AW)) ifb ();

  resize_scan_controller #(.WIDTH(4), .HEIGHT(3), .HBLANK(2), .ADDR_W(AW)) dut_a (
    .clock(clock), .reset(reset), .start(start), .stall(stall),
    .busy(busy_a), .frame_done(done_a), .bus(ifa)
  );

  resize_scan_controller #(.WIDTH(4), .HEIGHT(2), .HBLANK(0), .ADDR_W(AW)) dut_b (
    .clock(clock), .reset(reset), .start(start), .stall(stall),
    .busy(busy_b), .frame_done(done_b), .bus(ifb)
  );

  // Source pixel RAM with 1-cycle synchronous read, one port per instance.
  logic [23:0] mem [0:15];
  always @(posedge clock) begin
    if (ifa.rd_en) ifa.rd_data <= mem[ifa.rd_addr[3:0]];
    if (ifb.rd_en) ifb.rd_data <= mem[ifb.rd_addr[3:0]];
  end

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // Model state per instance.
  int          m_in[2];      // frame in progress
  int          m_iss[2];     // next address to be read
  int          m_blank[2];   // blanking cycles still owed
  int          m_tail[2];    // cycles left after the last read until frame_done is over
  int          m_p1[2];      // address read last cycle (-1 none)
  int          m_p2[2];      // address read two cycles ago (-1 none)
  logic [23:0] m_d1[2];
  logic [23:0] m_d2[2];
  logic [23:0] m_rgb[2];
  int          m_beats[2];
  int          m_scyc[2];
  int          m_done_rel[2];
  int          n_done[2];
  bit          exp_rd[2];

  function automatic int pw(input int d); return 4; endfunction
  function automatic int ph(input int d); return (d == 0) ? 3 : 2; endfunction
  function automatic int pb(input int d); return (d == 0) ? 2 : 0; endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_in[d] = 0; m_iss[d] = 0; m_blank[d] = 0; m_tail[d] = 0;
      m_p1[d] = -1; m_p2[d] = -1; m_d1[d] = '0; m_d2[d] = '0;
      m_rgb[d] = '0; m_beats[d] = 0; exp_rd[d] = 1'b0;
    end
  endtask

  task automatic check_dut(input int d, input logic o_rd, input logic [AW-1:0] o_addr,
                           input logic o_hs, input logic [23:0] o_rgb,
                           input logic [15:0] o_row, input logic [15:0] o_col,
                           input logic o_busy, input logic o_done);
    bit e_hs;
    exp_rd[d] = (m_in[d] != 0) && (m_tail[d] == 0) && (m_blank[d] == 0) && !stall;
    e_hs = (m_p2[d] >= 0);
    chk($sformatf("busy[%0d]", d), o_busy, m_in[d] != 0);
    chk($sformatf("frame_done[%0d]", d), o_done, m_tail[d] == 1);
    chk($sformatf("rd_en[%0d]", d), o_rd, exp_rd[d]);
    if (exp_rd[d]) chk($sformatf("rd_addr[%0d]", d), o_addr, m_iss[d]);
    chk($sformatf("hsync[%0d]", d), o_hs, e_hs);
    if (e_hs) begin
      chk($sformatf("rgb[%0d]", d), o_rgb, m_d2[d]);
      chk($sformatf("out_row[%0d]", d), o_row, m_p2[d] / pw(d));
      chk($sformatf("out_col[%0d]", d), o_col, m_p2[d] % pw(d));
    end else begin
      chk($sformatf("rgb_hold[%0d]", d), o_rgb, m_rgb[d]);
    end
    if (m_tail[d] == 1)
      chk($sformatf("beats[%0d]", d), m_beats[d], pw(d) * ph(d));
    if (o_done) begin
      n_done[d]++;
      m_done_rel[d] = cyc - m_scyc[d];
    end
  endtask

  task automatic update(input int d);
    if (m_p2[d] >= 0) begin
      m_rgb[d] = m_d2[d];
      m_beats[d]++;
    end
    m_p2[d] = m_p1[d];
    m_d2[d] = m_d1[d];
    m_p1[d] = exp_rd[d] ? m_iss[d] : -1;
    m_d1[d] = mem[m_iss[d] % 16];
    if (m_in[d] == 0) begin
      if (start) begin
        m_in[d] = 1; m_iss[d] = 0; m_blank[d] = 0; m_tail[d] = 0;
        m_beats[d] = 0; m_scyc[d] = cyc;
      end
    end else if (m_tail[d] > 0) begin
      m_tail[d]--;
      if (m_tail[d] == 0) m_in[d] = 0;
    end else if (exp_rd[d]) begin
      m_iss[d]++;
      if (m_iss[d] % pw(d) == 0) begin
        if (m_iss[d] == pw(d) * ph(d)) m_tail[d] = 3;
        else                           m_blank[d] = pb(d);
      end
    end else if (m_blank[d] > 0) begin
      m_blank[d]--;
    end
  endtask

  task automatic step(input logic st, input logic sl);
    @(posedge clock);
    #1;
    start = st;
    stall = sl;
    #1;
    cyc++;
    check_dut(0, ifa.rd_en, ifa.rd_addr, ifa.horizontal_sync, {ifa.r, ifa.g, ifa.b},
              ifa.out_row, ifa.out_col, busy_a, done_a);
    check_dut(1, ifb.rd_en, ifb.rd_addr, ifb.horizontal_sync, {ifb.r, ifb.g, ifb.b},
              ifb.out_row, ifb.out_col, busy_b, done_b);
    update(0);
    update(1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".rd_en_a"}, ifa.rd_en, 0);
    chk({tag, ".rd_addr_a"}, ifa.rd_addr, 0);
    chk({tag, ".hsync_a"}, ifa.horizontal_sync, 0);
    chk({tag, ".rgb_a"}, {ifa.r, ifa.g, ifa.b}, 0);
    chk({tag, ".rowcol_a"}, {ifa.out_row, ifa.out_col}, 0);
    chk({tag, ".busy_a"}, busy_a, 0);
    chk({tag, ".done_a"}, done_a, 0);
    chk({tag, ".rd_en_b"}, ifb.rd_en, 0);
    chk({tag, ".hsync_b"}, ifb.horizontal_sync, 0);
    chk({tag, ".busy_b"}, busy_b, 0);
    chk({tag, ".done_b"}, done_b, 0);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    model_reset();
    for (int i = 0; i < 16; i++) mem[i] = 24'(i);

    // Reset state.
    #12;
    check_all_zero("reset");
    @(posedge clock);
    #1;
    reset = 1'b1;

    // Plain frame, data = address, with a start pulse mid-frame that must be ignored.
    n_done[0] = 0; n_done[1] = 0;
    step(1'b1, 1'b0);
    for (int k = 1; k <= 22; k++) step(k == 5 || k == 12, 1'b0);
    chk("done_cycle_a", m_done_rel[0], 19);
    chk("done_cycle_b", m_done_rel[1], 11);
    chk("done_count_a", n_done[0], 1);
    chk("done_count_b", n_done[1], 1);

    // Stall for 5 cycles starting at column 1 of row 1.
    step(1'b1, 1'b0);
    for (int k = 1; k <= 7; k++)  step(1'b0, 1'b0);
    for (int k = 8; k <= 12; k++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("resume_rd_en", ifa.rd_en, 1);
    chk("resume_addr", ifa.rd_addr, 5);
    for (int k = 0; k < 20; k++) step(1'b0, 1'b0);

    // Reset mid-frame, then a fresh frame.
    n_done[0] = 0;
    step(1'b1, 1'b0);
    for (int k = 1; k <= 6; k++) step(1'b0, 1'b0);
    reset = 1'b0;
    #1;
    check_all_zero("midreset");
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    chk("midreset_no_done", n_done[0], 0);
    step(1'b1, 1'b0);
    for (int k = 0; k < 25; k++) step(1'b0, 1'b0);
    chk("fresh_done_count", n_done[0], 1);

    // Random pixel data, random stall, occasional start pulses (including while busy).
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < 16; i++) mem[i] = 24'($urandom);
      step(1'b1, 1'($urandom_range(0, 1)));
      for (int k = 0; k < 60; k++)
        step(k < 40 && $urandom_range(0, 19) == 0, k < 40 && $urandom_range(0, 9) < 3);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/resize_scan_controller.md
Name: resize_scan_controller

Overview:
- Raster-scan sequencer that feeds the 2x upscale output writer.
- Walks the source image memory in row-major order and issues one read per cycle. It presents each returned pixel as r/g/b with a horizontal_sync valid strobe, inserts programmable blanking between rows, and pulses frame_done after the last pixel.
- Sits between the source pixel RAM (1-cycle synchronous read) and the output writer/resizer.

Parameters:
- WIDTH, 768, source pixels per row (>=2)
- HEIGHT, 512, source rows (>=1)
- HBLANK, 160, idle cycles inserted between rows (0 allowed)
- ADDR_W, 20, read address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low
- start  in  1  begin one frame; sampled only in IDLE
- stall  in  1  sink back-pressure; blocks issue of new reads
- rd_en  out  1  source memory read strobe
- rd_addr  out  ADDR_W  source pixel address (row*WIDTH+col)
- rd_data  in  24  pixel {r,g,b}, valid the cycle after rd_en
- horizontal_sync  out  1  pixel valid strobe to the output writer
- r  out  8  red, registered
- g  out  8  green, registered
- b  out  8  blue, registered
- out_col  out  16  column of the beat currently on horizontal_sync
- out_row  out  16  row of the beat currently on horizontal_sync
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle end-of-frame pulse

Behaviour:
- Reset (asynchronous, active-low): clock clock; all outputs 0, state IDLE, all counters 0. Assertion mid-frame aborts immediately; no frame_done is produced. After release the block waits in IDLE for start.
- States: IDLE, ACTIVE, BLANK, DRAIN, DONE.
- IDLE: start=1 -> ACTIVE; col=0, row=0, address=0.
- ACTIVE with stall=0: rd_en=1, rd_addr=current address. After the issue, the address increments by 1 and col increments by 1. No multiplier is used; the address is kept incrementally.
- ACTIVE with stall=1: rd_en=0 and all counters hold. Reads already issued still complete: up to 2 horizontal_sync beats may follow the rise of stall, and the sink must absorb them.
- End of row (issue at col=WIDTH-1): col returns to 0.
  - If row=HEIGHT-1 -> DRAIN.
  - Else row+1; if HBLANK>0 -> BLANK, else stay in ACTIVE with no gap.
- BLANK: rd_en=0 for exactly HBLANK cycles, then -> ACTIVE. stall is ignored in BLANK and does not extend the blanking.
- DRAIN: 2 cycles while the pipeline empties, then -> DONE.
- DONE: frame_done=1 for exactly one cycle, then -> IDLE.
- Latency: rd_en in cycle t -> rd_data in t+1 -> r/g/b/horizontal_sync registered in t+2. out_row/out_col are delayed 2 stages to stay aligned with the pixel.
- r/g/b hold their last value when horizontal_sync=0.
- Exactly WIDTH*HEIGHT horizontal_sync beats per frame; the last beat is immediately followed by frame_done in the next cycle.
- busy=1 from the cycle after start is accepted through the frame_done cycle inclusive. start while busy=1 is ignored; there is no queuing.
- start and stall=1 in the same cycle: the frame is accepted, and the first read waits until stall=0.
- Counter widths: col and row are 16 bits; the address counter is ADDR_W bits and never wraps within a frame.

Test Plan:
- WIDTH=4, HEIGHT=3, HBLANK=2, stall=0, start sampled at edge E0. Required response:
  - rd_en high in cycles 1-4, 7-10 and 13-16, with rd_addr 0..11.
  - horizontal_sync high in cycles 3-6, 9-12 and 15-18.
  - frame_done high only in cycle 19; busy high in cycles 1-19.
- Same configuration, memory returns data = address. Required: r/g/b sequence {0,0,0}..{0,0,11} in order, with out_row/out_col going (0,0)..(2,3) aligned to each beat.
- HBLANK=0, WIDTH=4, HEIGHT=2. Required: 8 contiguous rd_en cycles, 8 contiguous horizontal_sync beats, frame_done 3 cycles after the last rd_en.
- stall held high for 5 cycles starting at col=1 of row 1. Required: at most 2 further beats after stall rises, then none; issue resumes at address 5 after stall falls; total beats = 12.
- start pulsed again mid-frame. Required: ignored, one frame_done only. reset pulsed low mid-frame. Required: all outputs 0 immediately, no frame_done; a fresh start then gives a full 12-beat frame from address 0.
